// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the VGA timing generator and the pixel generators
// that decode hCount/vCount into colour, plus the registered pin outputs.
interface vga_timing_gen_if;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic        bright;
   logic        pix_en;
   logic        frame_tick;
   logic [11:0] rgb_in;
   logic        vga_hs;
   logic        vga_vs;
   logic [11:0] vga_rgb;

   // Timing generator side: drives the raster and pins, reads colour back.
   modport master (
      output hCount, vCount, bright, pix_en, frame_tick,
      output vga_hs, vga_vs, vga_rgb,
      input  rgb_in
   );

   // Pixel generator / display side.
   modport slave (
      input  hCount, vCount, bright, pix_en, frame_tick,
      input  vga_hs, vga_vs, vga_rgb,
      output rgb_in
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source. Stage 0 is the pixel divider and the
// hCount/vCount counters with their combinational visible-window decode;
// stage 1 registers sync and the generator's colour on each pixel strobe so
// the pins change together, one pixel period behind the counters.
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   vga_timing_gen_if.master  vif
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
   // Last visible line; leaving it starts the vertical front porch.
   localparam logic [9:0]       V_TICK   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);

   // True when coordinate c lies in [lo, lo+len).
   function automatic logic in_span(input logic [9:0] c, input int lo, input int len);
      return (int'(c) >= lo) && (int'(c) < lo + len);
   endfunction

   // ---------------- stage 0: divider, counters, decode ----------------
   logic [DIV_W-1:0] div_p0;
   logic [9:0]       h_cnt_p0;
   logic [9:0]       v_cnt_p0;
   logic             vld_p0;
   logic             h_wrap_p0;
   logic             v_wrap_p0;
   logic             bright_p0;
   logic             tick_p0;

   assign vld_p0    = en && (div_p0 == DIV_LAST);
   assign h_wrap_p0 = (h_cnt_p0 == H_LAST);
   assign v_wrap_p0 = (v_cnt_p0 == V_LAST);
   assign bright_p0 = in_span(h_cnt_p0, H_SYNC + H_BACK, H_VISIBLE)
                   && in_span(v_cnt_p0, V_SYNC + V_BACK, V_VISIBLE);
   assign tick_p0   = vld_p0 && h_wrap_p0 && (v_cnt_p0 == V_TICK);

   // Pixel-rate divider: free-runs 0..CLK_DIV-1 while enabled, holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_p0 <= '0;
      end else if (en) begin
         div_p0 <= (div_p0 == DIV_LAST) ? '0 : div_p0 + DIV_W'(1);
      end
   end

   // Raster counters: advance one pixel per strobe, line advances on line wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt_p0 <= '0;
         v_cnt_p0 <= '0;
      end else if (vld_p0) begin
         h_cnt_p0 <= h_wrap_p0 ? 10'd0 : h_cnt_p0 + 10'd1;
         if (h_wrap_p0) begin
            v_cnt_p0 <= v_wrap_p0 ? 10'd0 : v_cnt_p0 + 10'd1;
         end
      end
   end

   // ---------------- stage 1: pin registers ----------------
   logic        hs_p1;
   logic        vs_p1;
   logic [11:0] rgb_p1;

   // Capture sync and blanked colour from the pre-increment stage-0 values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
         rgb_p1 <= '0;
      end else if (vld_p0) begin
         hs_p1  <= ~in_span(h_cnt_p0, 0, H_SYNC);
         vs_p1  <= ~in_span(v_cnt_p0, 0, V_SYNC);
         rgb_p1 <= bright_p0 ? vif.rgb_in : 12'h000;
      end
   end

   assign vif.hCount     = h_cnt_p0;
   assign vif.vCount     = v_cnt_p0;
   assign vif.bright     = bright_p0;
   assign vif.pix_en     = vld_p0;
   assign vif.frame_tick = tick_p0;
   assign vif.vga_hs     = hs_p1;
   assign vif.vga_vs     = vs_p1;
   assign vif.vga_rgb    = rgb_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (12x9 pixels,
// 4 clks per pixel) so whole frames fit in a short run. Expected values
// come from closed-form functions of the number of enabled clks since
// reset release.
module tb_vga_timing_gen;

   localparam int DIV = 4;
   localparam int HS = 3, HB = 2, HV = 5, HF = 2;
   localparam int VS = 2, VB = 2, VV = 3, VF = 2;
   localparam int HT = HS + HB + HV + HF;   // 12
   localparam int VT = VS + VB + VV + VF;   // 9
   localparam int FP = HT * VT;             // 108 pixels per frame

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b1;

   vga_timing_gen_if vif ();

   vga_timing_gen #(
      .CLK_DIV(DIV), .H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV), .V_FRONT(VF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .vif (vif)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_clk  = 0;   // enabled clk edges since reset release

   // ---- reference model ----
   function automatic int m_h(input int n);  return (n / DIV) % HT;          endfunction
   function automatic int m_v(input int n);  return ((n / DIV) / HT) % VT;   endfunction
   function automatic logic m_pix(input int n); return (n % DIV) == DIV - 1; endfunction
   function automatic logic m_tick(input int n);
      return m_pix(n) && ((n / DIV) % FP == HT * (VS + VB + VV) - 1);
   endfunction
   function automatic logic vis(input int h, input int v);
      return (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
   endfunction
   function automatic logic m_bright(input int n); return vis(m_h(n), m_v(n)); endfunction
   // Stage-1 values reflect the pixel before the current one (reset values before any).
   function automatic logic m_hs(input int n);
      int q;
      if (n / DIV == 0) return 1'b1;
      q = n / DIV - 1;
      return !((q % HT) < HS);
   endfunction
   function automatic logic m_vs(input int n);
      int q;
      if (n / DIV == 0) return 1'b1;
      q = n / DIV - 1;
      return !(((q / HT) % VT) < VS);
   endfunction
   function automatic logic [11:0] gen(input int h, input int v);
      return 12'((h << 6) | v) ^ 12'hA50;
   endfunction
   function automatic logic [11:0] m_rgb(input int n, input logic pattern);
      int q, h, v;
      if (n / DIV == 0) return 12'h000;
      q = n / DIV - 1;
      h = q % HT;
      v = (q / HT) % VT;
      if (!vis(h, v)) return 12'h000;
      return pattern ? gen(h, v) : 12'hFFF;
   endfunction

   task automatic step(input bit adv);
      @(posedge clk);
      if (adv) n_clk++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      vif.rgb_in = 12'hFFF;
      repeat (3) @(negedge clk);
      n_chk++; if (vif.hCount !== 10'd0) $display("FAIL rst_h got %0d want 0", vif.hCount); else n_pass++;
      n_chk++; if (vif.vCount !== 10'd0) $display("FAIL rst_v got %0d want 0", vif.vCount); else n_pass++;
      n_chk++; if (vif.pix_en !== 1'b0) $display("FAIL rst_pix got %b want 0", vif.pix_en); else n_pass++;
      n_chk++; if (vif.frame_tick !== 1'b0) $display("FAIL rst_tick got %b want 0", vif.frame_tick); else n_pass++;
      n_chk++; if (vif.vga_hs !== 1'b1) $display("FAIL rst_hs got %b want 1", vif.vga_hs); else n_pass++;
      n_chk++; if (vif.vga_vs !== 1'b1) $display("FAIL rst_vs got %b want 1", vif.vga_vs); else n_pass++;
      n_chk++; if (vif.vga_rgb !== 12'h000) $display("FAIL rst_rgb got %h want 000", vif.vga_rgb); else n_pass++;
      rst   = 1'b1;
      n_clk = 0;
      for (int i = 1; i <= 4; i++) begin
         step(1'b1);
         n_chk++;
         if (vif.pix_en !== (i == 3))
            $display("FAIL start_pix clk %0d got %b want %b", i, vif.pix_en, (i == 3));
         else n_pass++;
         n_chk++;
         if (vif.hCount !== ((i == 4) ? 10'd1 : 10'd0))
            $display("FAIL start_h clk %0d got %0d want %0d", i, vif.hCount, (i == 4) ? 1 : 0);
         else n_pass++;
         n_chk++;
         if (vif.vga_hs !== (i != 4))
            $display("FAIL start_hs clk %0d got %b want %b", i, vif.vga_hs, (i != 4));
         else n_pass++;
         n_chk++;
         if (vif.vga_rgb !== 12'h000)
            $display("FAIL start_rgb clk %0d got %h want 000", i, vif.vga_rgb);
         else n_pass++;
      end
   endtask

   task automatic test_free_run();
      int white = 0, hs_low = 0, vs_low = 0, ticks = 0;
      vif.rgb_in = 12'hFFF;
      for (int i = 0; i < 2 * FP * DIV; i++) begin
         step(1'b1);
         n_chk++; if (vif.hCount !== 10'(m_h(n_clk))) $display("FAIL run_h n=%0d got %0d want %0d", n_clk, vif.hCount, m_h(n_clk)); else n_pass++;
         n_chk++; if (vif.vCount !== 10'(m_v(n_clk))) $display("FAIL run_v n=%0d got %0d want %0d", n_clk, vif.vCount, m_v(n_clk)); else n_pass++;
         n_chk++; if (vif.pix_en !== m_pix(n_clk)) $display("FAIL run_pix n=%0d got %b want %b", n_clk, vif.pix_en, m_pix(n_clk)); else n_pass++;
         n_chk++; if (vif.frame_tick !== m_tick(n_clk)) $display("FAIL run_tick n=%0d got %b want %b", n_clk, vif.frame_tick, m_tick(n_clk)); else n_pass++;
         n_chk++; if (vif.bright !== m_bright(n_clk)) $display("FAIL run_bright n=%0d got %b want %b", n_clk, vif.bright, m_bright(n_clk)); else n_pass++;
         n_chk++; if (vif.vga_hs !== m_hs(n_clk)) $display("FAIL run_hs n=%0d got %b want %b", n_clk, vif.vga_hs, m_hs(n_clk)); else n_pass++;
         n_chk++; if (vif.vga_vs !== m_vs(n_clk)) $display("FAIL run_vs n=%0d got %b want %b", n_clk, vif.vga_vs, m_vs(n_clk)); else n_pass++;
         n_chk++; if (vif.vga_rgb !== m_rgb(n_clk, 1'b0)) $display("FAIL run_rgb n=%0d got %h want %h", n_clk, vif.vga_rgb, m_rgb(n_clk, 1'b0)); else n_pass++;
         if (vif.frame_tick === 1'b1) ticks++;
         if (n_clk % DIV == 0) begin
            if (vif.vga_rgb === 12'hFFF) white++;
            if (vif.vga_hs === 1'b0) hs_low++;
            if (vif.vga_vs === 1'b0) vs_low++;
         end
      end
      // Two frames: 2*5*3 white, 2*9*3 hsync-low, 2*2*12 vsync-low pixels.
      n_chk++; if (ticks !== 2) $display("FAIL frame_ticks got %0d want 2", ticks); else n_pass++;
      n_chk++; if (white !== 30) $display("FAIL white_pixels got %0d want 30", white); else n_pass++;
      n_chk++; if (hs_low !== 54) $display("FAIL hs_low_pixels got %0d want 54", hs_low); else n_pass++;
      n_chk++; if (vs_low !== 48) $display("FAIL vs_low_pixels got %0d want 48", vs_low); else n_pass++;
   endtask

   task automatic test_rgb_pattern();
      vif.rgb_in = gen(int'(vif.hCount), int'(vif.vCount));
      for (int i = 0; i < FP * DIV; i++) begin
         step(1'b1);
         vif.rgb_in = gen(int'(vif.hCount), int'(vif.vCount));
         if (n_clk % DIV == 0) begin
            n_chk++;
            if (vif.vga_rgb !== m_rgb(n_clk, 1'b1))
               $display("FAIL pat_rgb n=%0d got %h want %h", n_clk, vif.vga_rgb, m_rgb(n_clk, 1'b1));
            else n_pass++;
         end
      end
      vif.rgb_in = 12'hFFF;
   endtask

   task automatic test_enable_hold();
      int guard = 0;
      // Freeze inside a visible pixel, on the clk that would carry pix_en.
      while (!(m_pix(n_clk) && m_h(n_clk) == HS + HB + 1 && m_v(n_clk) == VS + VB + 1 && m_rgb(n_clk, 1'b0) == 12'hFFF) && guard < 2 * FP * DIV) begin
         step(1'b1);
         guard++;
      end
      n_chk++; if (guard >= 2 * FP * DIV) $display("FAIL hold_setup got %0d want <%0d", guard, 2 * FP * DIV); else n_pass++;
      en = 1'b0;
      #1;
      n_chk++; if (vif.pix_en !== 1'b0) $display("FAIL hold_pix_now got %b want 0", vif.pix_en); else n_pass++;
      for (int i = 0; i < 50; i++) begin
         step(1'b0);
         n_chk++; if (vif.pix_en !== 1'b0) $display("FAIL hold_pix got %b want 0", vif.pix_en); else n_pass++;
         n_chk++; if (vif.frame_tick !== 1'b0) $display("FAIL hold_tick got %b want 0", vif.frame_tick); else n_pass++;
         n_chk++; if (vif.hCount !== 10'(m_h(n_clk))) $display("FAIL hold_h got %0d want %0d", vif.hCount, m_h(n_clk)); else n_pass++;
         n_chk++; if (vif.vCount !== 10'(m_v(n_clk))) $display("FAIL hold_v got %0d want %0d", vif.vCount, m_v(n_clk)); else n_pass++;
         n_chk++; if (vif.vga_rgb !== m_rgb(n_clk, 1'b0)) $display("FAIL hold_rgb got %h want %h", vif.vga_rgb, m_rgb(n_clk, 1'b0)); else n_pass++;
         n_chk++; if (vif.vga_hs !== m_hs(n_clk)) $display("FAIL hold_hs got %b want %b", vif.vga_hs, m_hs(n_clk)); else n_pass++;
      end
      en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1);
         n_chk++; if (vif.hCount !== 10'(m_h(n_clk))) $display("FAIL resume_h n=%0d got %0d want %0d", n_clk, vif.hCount, m_h(n_clk)); else n_pass++;
         n_chk++; if (vif.pix_en !== m_pix(n_clk)) $display("FAIL resume_pix n=%0d got %b want %b", n_clk, vif.pix_en, m_pix(n_clk)); else n_pass++;
         n_chk++; if (vif.vga_rgb !== m_rgb(n_clk, 1'b0)) $display("FAIL resume_rgb n=%0d got %h want %h", n_clk, vif.vga_rgb, m_rgb(n_clk, 1'b0)); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      // Reach a point where hsync and vsync are both low and the counters are non-zero.
      while (!(m_hs(n_clk) == 1'b0 && m_vs(n_clk) == 1'b0 && m_h(n_clk) == 2 && n_clk % DIV == 1) && guard < 2 * FP * DIV) begin
         step(1'b1);
         guard++;
      end
      n_chk++; if (guard >= 2 * FP * DIV) $display("FAIL mid_setup got %0d want <%0d", guard, 2 * FP * DIV); else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_chk++; if (vif.hCount !== 10'd0) $display("FAIL mid_rst_h got %0d want 0", vif.hCount); else n_pass++;
      n_chk++; if (vif.vga_hs !== 1'b1) $display("FAIL mid_rst_hs got %b want 1", vif.vga_hs); else n_pass++;
      n_chk++; if (vif.vga_vs !== 1'b1) $display("FAIL mid_rst_vs got %b want 1", vif.vga_vs); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         step(1'b0);
         n_chk++; if (vif.frame_tick !== 1'b0) $display("FAIL mid_rst_tick got %b want 0", vif.frame_tick); else n_pass++;
         n_chk++; if (vif.pix_en !== 1'b0) $display("FAIL mid_rst_pix got %b want 0", vif.pix_en); else n_pass++;
         n_chk++; if (vif.hCount !== 10'd0) $display("FAIL mid_rst_hold_h got %0d want 0", vif.hCount); else n_pass++;
      end
      rst   = 1'b1;
      n_clk = 0;
      for (int i = 0; i < 3 * HT * DIV; i++) begin
         step(1'b1);
         n_chk++; if (vif.hCount !== 10'(m_h(n_clk))) $display("FAIL restart_h n=%0d got %0d want %0d", n_clk, vif.hCount, m_h(n_clk)); else n_pass++;
         n_chk++; if (vif.vCount !== 10'(m_v(n_clk))) $display("FAIL restart_v n=%0d got %0d want %0d", n_clk, vif.vCount, m_v(n_clk)); else n_pass++;
         n_chk++; if (vif.vga_hs !== m_hs(n_clk)) $display("FAIL restart_hs n=%0d got %b want %b", n_clk, vif.vga_hs, m_hs(n_clk)); else n_pass++;
      end
   endtask

   initial begin
      vif.rgb_in = 12'h000;
      test_reset();
      test_free_run();
      test_rgb_pattern();
      test_enable_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
